// File: rtl/gpio_defaults_shadow_if.sv
// Host-side bundle for gpio_defaults_shadow:
// config word access, transfer control and the serial chain pins.
interface gpio_defaults_shadow_if #(
  parameter int NUM_GPIO  = 38,
  parameter int CFG_WIDTH = 13
);
  localparam int IW = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;

  logic                 wr_en;
  logic [IW-1:0]        wr_idx;
  logic [CFG_WIDTH-1:0] wr_data;
  logic                 restore;
  logic [IW-1:0]        rd_idx;
  logic [CFG_WIDTH-1:0] rd_data;
  logic                 xfer_start;
  logic                 xfer_busy;
  logic                 xfer_done;
  logic                 serial_clock;
  logic                 serial_load;
  logic                 serial_data;

  modport master (
    output wr_en, wr_idx, wr_data,
    output restore, rd_idx, xfer_start,
    input  rd_data, xfer_busy, xfer_done,
    input  serial_clock, serial_load,
    input  serial_data
  );

  modport slave (
    input  wr_en, wr_idx, wr_data,
    input  restore, rd_idx, xfer_start,
    output rd_data, xfer_busy, xfer_done,
    output serial_clock, serial_load,
    output serial_data
  );
endinterface

// File: rtl/gpio_defaults_shadow.sv
// GPIO config shadow registers with mask defaults
// and a serial streamer into the pad control chain.
module gpio_defaults_shadow #(
  parameter int NUM_GPIO  = 38,
  parameter int CFG_WIDTH = 13,
  parameter logic [NUM_GPIO*CFG_WIDTH-1:0]
    CONFIG_INIT = {NUM_GPIO{13'h0402}},
  parameter int CLK_DIV   = 2
) (
  input logic                 clk,
  input logic                 resetn,
  gpio_defaults_shadow_if.slave bus
);
  localparam int TOTAL = NUM_GPIO * CFG_WIDTH;
  localparam int IW = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;
  localparam int KW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [IW:0] NG = (IW+1)'(NUM_GPIO);

  typedef enum logic [1:0] {
    IDLE, SHIFT_LO, SHIFT_HI, LOAD
  } state_t;

  state_t           r_state, w_state;
  logic [PW-1:0]    r_ph, w_ph;
  logic [KW-1:0]    r_k, w_k;
  logic [TOTAL-1:0] r_cfg, w_cfg;
  logic             r_busy, r_done;
  logic             r_sclk, r_sload, r_sdata;
  logic             w_busy, w_done;
  logic             w_sclk, w_sload, w_sdata;
  logic             w_last, w_wr_ok, w_rd_ok;
  int               w_wr_off, w_rd_off;

  assign w_last   = (r_ph == PW'(CLK_DIV - 1));
  assign w_wr_ok  = ({1'b0, bus.wr_idx} < NG);
  assign w_rd_ok  = ({1'b0, bus.rd_idx} < NG);
  assign w_wr_off = int'(bus.wr_idx) * CFG_WIDTH;
  assign w_rd_off = int'(bus.rd_idx) * CFG_WIDTH;

  always_comb begin
    bus.rd_data = '0;
    if (w_rd_ok)
      bus.rd_data = r_cfg[w_rd_off +: CFG_WIDTH];
  end

  always_comb begin
    w_state = r_state;
    w_ph    = r_ph;
    w_k     = r_k;
    w_cfg   = r_cfg;
    unique case (r_state)
      IDLE: begin
        if (bus.restore)
          w_cfg = CONFIG_INIT;
        else if (bus.wr_en && w_wr_ok)
          w_cfg[w_wr_off +: CFG_WIDTH] = bus.wr_data;
        if (bus.xfer_start) begin
          w_state = SHIFT_LO;
          w_ph    = '0;
          w_k     = KW'(TOTAL - 1);
        end
      end
      SHIFT_LO: begin
        if (w_last) begin
          w_state = SHIFT_HI;
          w_ph    = '0;
        end else begin
          w_ph = r_ph + PW'(1);
        end
      end
      SHIFT_HI: begin
        if (w_last) begin
          w_ph = '0;
          if (r_k != '0) begin
            w_k     = r_k - KW'(1);
            w_state = SHIFT_LO;
          end else begin
            w_state = LOAD;
          end
        end else begin
          w_ph = r_ph + PW'(1);
        end
      end
      LOAD: begin
        if (w_last) begin
          w_state = IDLE;
          w_ph    = '0;
        end else begin
          w_ph = r_ph + PW'(1);
        end
      end
    endcase
  end

  // Serial pins are registered from next-state values;
  // w_cfg makes a same-cycle write visible to bit one.
  always_comb begin
    w_busy  = (w_state != IDLE);
    w_done  = (r_state == LOAD) && (w_state == IDLE);
    w_sclk  = (w_state == SHIFT_HI);
    w_sload = (w_state == LOAD);
    w_sdata = 1'b0;
    if (w_state == SHIFT_LO || w_state == SHIFT_HI)
      w_sdata = w_cfg[w_k];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_ph    <= '0;
      r_k     <= '0;
      r_cfg   <= CONFIG_INIT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sload <= 1'b0;
      r_sdata <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ph    <= w_ph;
      r_k     <= w_k;
      r_cfg   <= w_cfg;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_sclk  <= w_sclk;
      r_sload <= w_sload;
      r_sdata <= w_sdata;
    end
  end

  assign bus.xfer_busy    = r_busy;
  assign bus.xfer_done    = r_done;
  assign bus.serial_clock = r_sclk;
  assign bus.serial_load  = r_sload;
  assign bus.serial_data  = r_sdata;
endmodule

// File: tb/tb_gpio_defaults_shadow.sv
// Bench for gpio_defaults_shadow: two configurations
// checked every cycle against a timeline model.
module tb_gpio_defaults_shadow;
  localparam int CW = 13;
  localparam int NA = 5;
  localparam int DA = 3;
  localparam int TA = NA * CW;
  localparam int NB = 2;
  localparam int DB = 1;
  localparam int TB = NB * CW;
  localparam logic [TA-1:0] INITA = {13'h0402,
    13'h1FFF, 13'h0007, 13'h1803, 13'h0402};
  localparam logic [TB-1:0] INITB = {2{13'h0402}};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  gpio_defaults_shadow_if #(.NUM_GPIO(NA), .CFG_WIDTH(CW)) ifa ();
  gpio_defaults_shadow_if #(.NUM_GPIO(NB), .CFG_WIDTH(CW)) ifb ();

  gpio_defaults_shadow #(
    .NUM_GPIO(NA), .CFG_WIDTH(CW),
    .CONFIG_INIT(INITA), .CLK_DIV(DA)
  ) ua (.clk(clk), .resetn(resetn), .bus(ifa));

  gpio_defaults_shadow #(
    .NUM_GPIO(NB), .CFG_WIDTH(CW),
    .CONFIG_INIT(INITB), .CLK_DIV(DB)
  ) ub (.clk(clk), .resetn(resetn), .bus(ifb));

  int vectors = 0;
  int errs = 0;
  bit chk_en = 0;

  logic [CW-1:0] mw [2][8];
  bit mact [2];
  bit mdone [2];
  int mt [2];

  function automatic int ng(int u);
    return (u == 0) ? NA : NB;
  endfunction
  function automatic int dv(int u);
    return (u == 0) ? DA : DB;
  endfunction

  function automatic logic [CW-1:0] dflt(int u, int c);
    logic [TA-1:0] va;
    logic [TB-1:0] vb;
    va = INITA;
    vb = INITB;
    if (u == 0) return va[c*CW +: CW];
    return vb[c*CW +: CW];
  endfunction

  task automatic mreset();
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 8; c++)
        mw[u][c] = (c < ng(u)) ? dflt(u, c) : '0;
      mact[u] = 0;
      mdone[u] = 0;
      mt[u] = 0;
    end
  endtask

  task automatic mstep(int u, logic we, logic [2:0] wi,
                       logic [CW-1:0] wd, logic rs, logic xs);
    int len;
    len = (2 * ng(u) * CW + 1) * dv(u);
    mdone[u] = 0;
    if (!mact[u]) begin
      if (rs)
        for (int c = 0; c < ng(u); c++) mw[u][c] = dflt(u, c);
      else if (we && int'(wi) < ng(u))
        mw[u][wi] = wd;
      if (xs) begin
        mact[u] = 1;
        mt[u] = 0;
      end
    end else begin
      mt[u]++;
      if (mt[u] == len) begin
        mact[u] = 0;
        mdone[u] = 1;
      end
    end
  endtask

  // {busy, done, serial_clock, serial_load, serial_data}
  function automatic logic [4:0] mexp(int u);
    int t, d, j, k;
    logic sc, sl, sd;
    t = ng(u) * CW;
    d = dv(u);
    sc = 0; sl = 0; sd = 0;
    if (mact[u]) begin
      if (mt[u] < 2 * t * d) begin
        j = mt[u] / (2 * d);
        k = t - 1 - j;
        sc = (mt[u] % (2 * d)) >= d;
        sd = mw[u][k / CW][k % CW];
      end else begin
        sl = 1;
      end
    end
    return {mact[u], mdone[u], sc, sl, sd};
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) mreset();
    else begin
      mstep(0, ifa.wr_en, ifa.wr_idx, ifa.wr_data,
            ifa.restore, ifa.xfer_start);
      mstep(1, ifb.wr_en, {2'b00, ifb.wr_idx}, ifb.wr_data,
            ifb.restore, ifb.xfer_start);
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] outs_a();
    return {ifa.xfer_busy, ifa.xfer_done, ifa.serial_clock,
            ifa.serial_load, ifa.serial_data};
  endfunction
  function automatic logic [4:0] outs_b();
    return {ifb.xfer_busy, ifb.xfer_done, ifb.serial_clock,
            ifb.serial_load, ifb.serial_data};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc A outs", 32'(outs_a()), 32'(mexp(0)));
      check("cyc B outs", 32'(outs_b()), 32'(mexp(1)));
      check("cyc A rd", 32'(ifa.rd_data),
            (int'(ifa.rd_idx) < NA) ? 32'(mw[0][ifa.rd_idx]) : 0);
      check("cyc B rd", 32'(ifb.rd_data),
            32'(mw[1][ifb.rd_idx]));
    end
  end

  logic [TB-1:0] capb = '0;
  int ncapb = 0;
  int nloadb = 0;
  int ndoneb = 0;
  int ndonea = 0;
  always @(posedge ifb.serial_clock) begin
    capb = {capb[TB-2:0], ifb.serial_data};
    ncapb++;
  end
  always @(posedge ifb.serial_load) nloadb++;
  always @(negedge clk) begin
    if (ifb.xfer_done) ndoneb++;
    if (ifa.xfer_done) ndonea++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ifa.wr_en = 0; ifa.restore = 0; ifa.xfer_start = 0;
    ifb.wr_en = 0; ifb.restore = 0; ifb.xfer_start = 0;
  endtask

  task automatic wait_idle(input string nm, input int lim,
                           output int n);
    n = 0;
    while ((nm[0] == "A" ? ifa.xfer_busy : ifb.xfer_busy)
           && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) check({nm, " busy timeout"}, 32'(n), 32'(lim - 1));
  endtask

  logic [CW-1:0] lit [5];
  int n, m;

  initial begin
    lit = '{13'h0402, 13'h1803, 13'h0007, 13'h1FFF, 13'h0402};
    clr_in();
    ifa.wr_idx = 0; ifa.wr_data = 0; ifa.rd_idx = 0;
    ifb.wr_idx = 0; ifb.wr_data = 0; ifb.rd_idx = 0;
    mreset();
    chk_en = 1;
    repeat (3) tick();
    resetn = 1;
    tick();

    for (int c = 0; c < 5; c++) begin
      ifa.rd_idx = 3'(c);
      #1 check("reset rd A", 32'(ifa.rd_data), 32'(lit[c]));
    end
    check("reset outs A", 32'(outs_a()), 0);
    check("reset outs B", 32'(outs_b()), 0);

    ifa.wr_en = 1; ifa.wr_idx = 2; ifa.wr_data = 13'h0ABC;
    tick();
    clr_in();
    ifa.rd_idx = 2;
    #1 check("write rd2", 32'(ifa.rd_data), 32'h0ABC);
    ifa.restore = 1;
    tick();
    clr_in();
    #1 check("restore rd2", 32'(ifa.rd_data), 32'h0007);

    ifa.wr_en = 1; ifa.wr_idx = 5; ifa.wr_data = 13'h1555;
    tick();
    clr_in();
    for (int c = 0; c < 5; c++) begin
      ifa.rd_idx = 3'(c);
      #1 check("oob write", 32'(ifa.rd_data), 32'(lit[c]));
    end

    ifa.restore = 1;
    ifa.wr_en = 1; ifa.wr_idx = 1; ifa.wr_data = 0;
    tick();
    clr_in();
    ifa.rd_idx = 1;
    #1 check("restore prio", 32'(ifa.rd_data), 32'h1803);

    capb = '0; ncapb = 0; nloadb = 0; ndoneb = 0;
    ifb.wr_en = 1; ifb.wr_idx = 0; ifb.wr_data = 13'h1000;
    tick();
    ifb.wr_idx = 1; ifb.wr_data = 13'h0001;
    ifb.xfer_start = 1;
    tick();
    clr_in();
    wait_idle("B", 200, n);
    tick();
    check("B busy len", 32'(n), 32'd53);
    check("B bits", 32'(capb), 32'h0003000);
    check("B nbits", 32'(ncapb), 32'd26);
    check("B loads", 32'(nloadb), 32'd1);
    check("B dones", 32'(ndoneb), 32'd1);

    ndonea = 0;
    ifa.xfer_start = 1;
    tick();
    clr_in();
    n = 0;
    while (!ifa.serial_clock && n < 50) begin tick(); n++; end
    check("A lo phase", 32'(n), 32'd3);
    m = 0;
    while (ifa.serial_clock && m < 50) begin tick(); m++; end
    check("A hi phase", 32'(m), 32'd3);
    ifa.wr_en = 1; ifa.wr_idx = 0; ifa.wr_data = 13'h1111;
    ifa.xfer_start = 1; ifa.restore = 1;
    tick();
    clr_in();
    wait_idle("A", 1000, n);
    repeat (5) tick();
    check("A no requeue", 32'(ifa.xfer_busy), 0);
    check("A dones", 32'(ndonea), 32'd1);
    ifa.rd_idx = 0;
    #1 check("A lockout rd0", 32'(ifa.rd_data), 32'h0402);

    ncapb = 0; nloadb = 0;
    ifb.xfer_start = 1;
    tick();
    clr_in();
    n = 0;
    while (ncapb < 10 && n < 100) begin tick(); n++; end
    #2 resetn = 0;
    #1 check("arst outs B", 32'(outs_b()), 0);
    check("arst outs A", 32'(outs_a()), 0);
    ifb.rd_idx = 0;
    #1 check("arst rd B0", 32'(ifb.rd_data), 32'h0402);
    ifb.rd_idx = 1;
    #1 check("arst rd B1", 32'(ifb.rd_data), 32'h0402);
    tick(); tick();
    resetn = 1;
    tick();
    check("arst no load", 32'(nloadb), 0);
    capb = '0; ncapb = 0;
    ifb.xfer_start = 1;
    tick();
    clr_in();
    wait_idle("B", 200, n);
    tick();
    check("B restart bits", 32'(capb), 32'h0804402);
    check("B restart n", 32'(ncapb), 32'd26);
    check("B restart load", 32'(nloadb), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      ifa.wr_en = ($urandom_range(0, 3) == 0);
      ifa.wr_idx = 3'($urandom_range(0, 7));
      ifa.wr_data = CW'($urandom);
      ifa.restore = ($urandom_range(0, 19) == 0);
      ifa.xfer_start = ($urandom_range(0, 59) == 0);
      ifa.rd_idx = 3'($urandom_range(0, 7));
      ifb.wr_en = ($urandom_range(0, 2) == 0);
      ifb.wr_idx = 1'($urandom_range(0, 1));
      ifb.wr_data = CW'($urandom);
      ifb.restore = ($urandom_range(0, 19) == 0);
      ifb.xfer_start = ($urandom_range(0, 29) == 0);
      ifb.rd_idx = 1'($urandom_range(0, 1));
      tick();
    end
    clr_in();
    tick();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
